// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush controller: stall levels,
// stage indices and the branch-redirect sequencer states.
package pipeline_ctrl_pkg;

  localparam logic Stop      = 1'b1;
  localparam logic NoStop    = 1'b0;
  localparam logic RstEnable = 1'b0;

  localparam int StallBusW = 6;
  typedef logic [StallBusW-1:0] stall_bus_t;

  localparam int StallPc  = 0;
  localparam int StallIf  = 1;
  localparam int StallId  = 2;
  localparam int StallEx  = 3;
  localparam int StallMem = 4;
  localparam int StallWb  = 5;

  typedef enum logic [1:0] {
    CtrlIdle  = 2'd0,
    CtrlPend  = 2'd1,
    CtrlRedir = 2'd2
  } ctrl_state_e;

  // Number of stages, counted from pc upward, held in Stop by the
  // highest-priority requester; everything at or below it freezes.
  function automatic int stallLevel(input logic ifReq, input logic idReq,
                                    input logic exReq, input logic memReq);
    int level;
    level = 0;
    if (memReq)      level = StallMem + 1;
    else if (exReq)  level = StallEx + 1;
    else if (idReq)  level = StallId + 1;
    else if (ifReq)  level = StallIf + 1;
    return level;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Free-running event counter that sticks at all-ones instead of wrapping.
module sat_counter
  import pipeline_ctrl_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush producer: merges per-stage stall requests into one
// stall vector and sequences taken-branch redirects into the pc register.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int STALL_W = 6,
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic               id_req,
  input  logic               ex_req,
  input  logic               mem_req,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic               redir_valid,
  output logic [ADDR_W-1:0]  redir_pc,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  ctrl_state_e       state_q;
  logic              redir_valid_q;
  logic [ADDR_W-1:0] redir_pc_q;
  logic [STALL_W-1:0] stall_d;
  logic              brAcc;
  int                level;

  // Stall is purely combinational so a hazard freezes its stages in the
  // same cycle it is raised; it is held off entirely while in reset.
  always_comb begin
    stall_d = '0;
    level   = stallLevel(if_req, id_req, ex_req, mem_req);
    for (int i = 0; i < STALL_W; i++) begin
      stall_d[i] = (i < level);
    end
    if (rst == RstEnable) begin
      stall_d = '0;
    end
  end

  assign stall = stall_d;

  // A branch is only taken up when EX is actually advancing and no earlier
  // redirect is still being sequenced.
  assign brAcc = (rst != RstEnable) && br_taken && (stall_d[StallEx] == NoStop)
                 && (state_q == CtrlIdle);

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      state_q       <= CtrlIdle;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
    end else begin
      case (state_q)
        CtrlIdle: begin
          if (brAcc) begin
            redir_pc_q <= br_target;
            if (if_req) begin
              state_q <= CtrlPend;
            end else begin
              state_q       <= CtrlRedir;
              redir_valid_q <= 1'b1;
            end
          end
        end
        CtrlPend: begin
          if (!if_req) begin
            state_q       <= CtrlRedir;
            redir_valid_q <= 1'b1;
          end
        end
        CtrlRedir: begin
          state_q       <= CtrlIdle;
          redir_valid_q <= 1'b0;
        end
        default: begin
          state_q       <= CtrlIdle;
          redir_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign flush       = brAcc || (state_q != CtrlIdle);
  assign redir_valid = redir_valid_q;
  assign redir_pc    = redir_pc_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (|stall_d),
    .q   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (brAcc),
    .q   (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a driver predicts each cycle's outputs
// from a behavioural model and a negedge monitor compares them.
module tb_pipeline_ctrl;

  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          ifReq, idReq, exReq, memReq, brTaken;
  logic [31:0]   brTarget;
  logic [5:0]    stall;
  logic          flush, redirValid;
  logic [31:0]   redirPc;
  logic [CW-1:0] stallCnt, flushCnt;

  typedef struct {
    logic [5:0]    stall;
    logic          flush;
    logic          rv;
    logic [31:0]   pc;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model state: a branch waiting on fetch, a redirect due now.
  bit          mWaitFetch;
  bit          mRedirNow;
  logic [31:0] mTarget;
  int          mStallCnt, mFlushCnt;

  pipeline_ctrl #(.STALL_W(6), .ADDR_W(32), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (ifReq),
    .id_req      (idReq),
    .ex_req      (exReq),
    .mem_req     (memReq),
    .br_taken    (brTaken),
    .br_target   (brTarget),
    .stall       (stall),
    .flush       (flush),
    .redir_valid (redirValid),
    .redir_pc    (redirPc),
    .stall_cnt   (stallCnt),
    .flush_cnt   (flushCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic fi, input logic di,
                               input logic ei, input logic mi, input logic bt,
                               input logic [31:0] tgt);
    exp_t e;
    int   frozen;
    bit   idle, acc;
    @(posedge clk);
    #1;
    rst = r; ifReq = fi; idReq = di; exReq = ei; memReq = mi;
    brTaken = bt; brTarget = tgt;
    if (!r) begin
      mWaitFetch = 0; mRedirNow = 0; mTarget = '0;
      mStallCnt = 0; mFlushCnt = 0;
    end
    // stages frozen = stages up to and including the requesting one
    frozen = !r ? 0 : mi ? 5 : ei ? 4 : di ? 3 : fi ? 2 : 0;
    e.stall = 6'((64'd1 << frozen) - 1);
    idle    = !mWaitFetch && !mRedirNow;
    acc     = r && bt && (frozen < 4) && idle;
    e.flush = acc || !idle;
    e.rv    = mRedirNow;
    e.pc    = mTarget;
    e.sc    = CW'(mStallCnt);
    e.fc    = CW'(mFlushCnt);
    expQ.push_back(e);
    if (r) begin
      if (frozen != 0 && mStallCnt < (1 << CW) - 1) mStallCnt++;
      if (acc) begin
        mTarget = tgt;
        if (mFlushCnt < (1 << CW) - 1) mFlushCnt++;
        mWaitFetch = fi;
        mRedirNow  = !fi;
      end else if (mWaitFetch && !fi) begin
        mWaitFetch = 0;
        mRedirNow  = 1;
      end else begin
        mRedirNow = 0;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents outputs; pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("stall",       32'(stall),      32'(e.stall));
        checkOutput("flush",       32'(flush),      32'(e.flush));
        checkOutput("redir_valid", 32'(redirValid), 32'(e.rv));
        checkOutput("redir_pc",    redirPc,         e.pc);
        checkOutput("stall_cnt",   32'(stallCnt),   32'(e.sc));
        checkOutput("flush_cnt",   32'(flushCnt),   32'(e.fc));
      end
    end
  end

  initial begin
    bit r, bt;
    rst = 1'b0; ifReq = 0; idReq = 0; exReq = 0; memReq = 0;
    brTaken = 0; brTarget = '0;
    mWaitFetch = 0; mRedirNow = 0; mTarget = '0; mStallCnt = 0; mFlushCnt = 0;

    $display("[TB] reset and stall priority");
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
    applyStimulus(1, 0, 1, 0, 1, 0, 32'h0);
    applyStimulus(1, 0, 1, 0, 0, 0, 32'h0);
    applyStimulus(1, 1, 0, 0, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 1, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);

    $display("[TB] branch with fetch idle");
    applyStimulus(1, 0, 0, 0, 0, 1, 32'h0000_0100);
    repeat (2) applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);

    $display("[TB] branch with fetch busy");
    applyStimulus(1, 1, 0, 0, 0, 1, 32'h0000_0200);
    repeat (3) applyStimulus(1, 1, 0, 0, 0, 0, 32'h0);
    repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);

    $display("[TB] branch blocked by ex stall");
    applyStimulus(1, 0, 0, 1, 0, 1, 32'h0000_0300);
    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);

    $display("[TB] reset while redirect pending");
    applyStimulus(1, 1, 0, 0, 0, 1, 32'h0000_0400);
    applyStimulus(1, 1, 0, 0, 0, 0, 32'h0);
    repeat (2) applyStimulus(0, 1, 1, 1, 1, 0, 32'h0);
    repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);

    $display("[TB] counter saturation");
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
    repeat (20) applyStimulus(1, 0, 1, 0, 0, 0, 32'h0);
    repeat (2) applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 39) != 0);
      bt = r && ($urandom_range(0, 3) == 0);
      applyStimulus(r, $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0,
                    bt, $urandom);
    end

    @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: %0d expected entries left, 0 required", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
